// File: rtl/fifo.sv
// Self-exercising 8x8 synchronous FIFO with a built-in traffic generator and
// in-order checker; driven only by clock and a synchronous active-low reset.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input logic clk1,
    input logic rst
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0]  PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [WIDTH-1:0] DATA_ONE = WIDTH'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [ADDR_W:0]  wr_ptr   = '0;
    logic [ADDR_W:0]  rd_ptr   = '0;
    logic [WIDTH-1:0] wr_data  = '0;
    logic [WIDTH-1:0] exp_data = '0;
    logic [4:0]       tick     = '0;
    logic             err      = 1'b0;

    logic [ADDR_W:0]  count;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] rd_data;
    logic             wr_req;
    logic             rd_req;
    logic             wr_ok;
    logic             rd_ok;

    // The extra pointer MSB distinguishes a full buffer from an empty one.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    assign wr_req  = (tick < 5'd10) || (tick >= 5'd20);
    assign rd_req  = (tick >= 5'd10);
    assign wr_ok   = wr_req && !full;
    assign rd_ok   = rd_req && !empty;

    always_ff @(posedge clk1) begin
        if (rst && wr_ok) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            wr_data  <= '0;
            exp_data <= '0;
            tick     <= '0;
            err      <= 1'b0;
        end else begin
            if (tick != 5'd20) begin
                tick <= tick + 5'd1;
            end
            if (wr_ok) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                wr_data <= wr_data + DATA_ONE;
            end
            // The head is checked against the expected sequence as it leaves.
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                exp_data <= exp_data + DATA_ONE;
                if (rd_data != exp_data) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: a queue-based reference model tracks the
// generator schedule and is compared against the DUT's internal state.
module tb_fifo;

    logic clk1 = 1'b0;
    logic rst  = 1'b1;

    int errorCount = 0;
    int checkCount = 0;
    int cycleNum   = 0;

    int q[$];
    int mTick    = 0;
    int mWrData  = 0;
    int mExpData = 0;
    int mErr     = 0;
    int mWrPtr   = 0;
    int mRdPtr   = 0;

    fifo dut (
        .clk1(clk1),
        .rst (rst)
    );

    always #5 clk1 = ~clk1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycleNum, observed, expected);
        end
    endtask

    // Reference behaviour: decide push/pop from the pre-edge state, then apply.
    task automatic modelEdge(input bit resetNow);
        bit wreq, rreq, pushOk, popOk;
        if (resetNow) begin
            q.delete();
            mTick = 0; mWrData = 0; mExpData = 0; mErr = 0; mWrPtr = 0; mRdPtr = 0;
        end else begin
            wreq   = (mTick < 10) || (mTick >= 20);
            rreq   = (mTick >= 10);
            pushOk = wreq && (q.size() < 8);
            popOk  = rreq && (q.size() > 0);
            if (popOk) begin
                if (q[0] != mExpData) mErr = 1;
                void'(q.pop_front());
                mExpData = (mExpData + 1) % 256;
                mRdPtr   = (mRdPtr + 1) % 16;
            end
            if (pushOk) begin
                q.push_back(mWrData);
                mWrData = (mWrData + 1) % 256;
                mWrPtr  = (mWrPtr + 1) % 16;
            end
            if (mTick < 20) mTick++;
        end
    endtask

    task automatic checkAll();
        checkOutput("count",    int'(dut.count),    q.size());
        checkOutput("full",     int'(dut.full),     (q.size() == 8) ? 1 : 0);
        checkOutput("empty",    int'(dut.empty),    (q.size() == 0) ? 1 : 0);
        checkOutput("tick",     int'(dut.tick),     mTick);
        checkOutput("wr_data",  int'(dut.wr_data),  mWrData);
        checkOutput("exp_data", int'(dut.exp_data), mExpData);
        checkOutput("err",      int'(dut.err),      mErr);
        checkOutput("wr_ptr",   int'(dut.wr_ptr),   mWrPtr);
        checkOutput("rd_ptr",   int'(dut.rd_ptr),   mRdPtr);
        if (q.size() > 0) begin
            checkOutput("rd_data", int'(dut.rd_data), q[0]);
        end
    endtask

    // One edge per iteration; rst is driven low for that edge when requested.
    task automatic applyStimulus(input bit resetNow, input int edges);
        for (int i = 0; i < edges; i++) begin
            rst = resetNow ? 1'b0 : 1'b1;
            @(posedge clk1);
            cycleNum++;
            modelEdge(resetNow);
            #1;
            checkAll();
        end
        rst = 1'b1;
    endtask

    initial begin
        #1;
        checkAll();

        // Power-up without any reset edge.
        applyStimulus(1'b0, 30);

        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 8);
        checkOutput("fill.count",   int'(dut.count),   8);
        checkOutput("fill.full",    int'(dut.full),    1);
        checkOutput("fill.wr_data", int'(dut.wr_data), 8);
        checkOutput("fill.rd_data", int'(dut.rd_data), 0);
        applyStimulus(1'b0, 2);
        checkOutput("overrun.wr_ptr",  int'(dut.wr_ptr),  8);
        checkOutput("overrun.rd_data", int'(dut.rd_data), 0);
        applyStimulus(1'b0, 10);
        checkOutput("drain.exp_data", int'(dut.exp_data), 8);
        checkOutput("drain.rd_ptr",   int'(dut.rd_ptr),   8);
        checkOutput("drain.empty",    int'(dut.empty),    1);
        applyStimulus(1'b0, 10);
        checkOutput("stream.count",   int'(dut.count),   1);
        checkOutput("stream.wr_data", int'(dut.wr_data), 18);
        checkOutput("stream.err",     int'(dut.err),     0);

        // Reset landing on edge 5 restarts the generator.
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 1);
        checkOutput("midreset.tick",  int'(dut.tick),  0);
        checkOutput("midreset.count", int'(dut.count), 0);
        applyStimulus(1'b0, 1);
        checkOutput("restart.wr_data", int'(dut.wr_data), 1);
        checkOutput("restart.rd_data", int'(dut.rd_data), 0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), 1);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fifo.md
# fifo

Self-exercising synchronous FIFO: an 8-entry × 8-bit first-in-first-out buffer with an on-chip traffic generator and an in-order checker. It is a standalone smoke-test block driven only by clock and reset. All state is observed hierarchically: `count`, `full`, `empty`, `rd_data`, `wr_data`, `exp_data`, `tick`, `err`.

## Interface
- WIDTH, 8, data width in bits.
- DEPTH, 8, number of entries (power of two); ADDR_W = log2(DEPTH).
- clk1  input  1  clock, all logic on rising edge.
- rst  input  1  reset: one clock; reset is synchronous and active-low (sampled only on clk1 rising edge; rst=0 at an edge clears state).
- No other ports.
- Port order is exactly (clk1, rst) for positional hookup.

## Operation
- Storage: `mem[DEPTH]` of WIDTH bits.
  - `wr_ptr` and `rd_ptr` are ADDR_W+1 bits each; the MSB is the wrap flag.
  - `count` is ADDR_W+1 bits.
  - `empty` = (wr_ptr == rd_ptr).
  - `full` = (low bits equal and MSBs differ).
  - `count` = wr_ptr − rd_ptr, modulo 2^(ADDR_W+1).
- `rd_data` = mem[rd_ptr[ADDR_W-1:0]], combinational (show-ahead).
- Push: `wr_ok` = wr_req & ~full.
  - On a push, mem[wr_ptr] ← wr_data, wr_ptr+1, wr_data+1 (8-bit wrap).
- Pop: `rd_ok` = rd_req & ~empty.
  - On a pop, rd_ptr+1.
  - The checker compares rd_data to exp_data; on mismatch err ← 1 (sticky until reset).
  - exp_data+1.
- Simultaneous push and pop are both performed; count is unchanged. A blocked request has no effect and is not an error.
- Traffic generator: 5-bit `tick` increments every edge and saturates at 20. Requests are decoded from the current tick:
  - tick 0–9: wr_req=1, rd_req=0 (fill, then overrun attempts).
  - tick 10–19: wr_req=0, rd_req=1 (drain, then underrun attempts).
  - tick ≥20: wr_req=1, rd_req=1 (streaming).
- Reset and power-up values:
  - wr_ptr = rd_ptr = 0; count = 0; empty = 1; full = 0.
  - tick = 0; wr_data = 0; exp_data = 0; err = 0.
  - mem contents are don't-care.
  - All registers carry these as declaration initial values, so the block runs correctly even if no reset edge is ever seen.

## Timing
- Pushes and pops take effect on the edge where they are requested.
- Flags and count are valid the cycle after that edge; there is no extra latency.
- rd_data reflects the new head immediately after a pop edge. The first write into an empty FIFO is visible on rd_data right after its edge.
- Reset has priority over every other action. A reset mid-operation discards contents, returns all registers to reset values, and restarts the generator at tick 0.
- Sequence with edges E1.. after reset:
  - E1–E8: writes 0..7; full=1 after E8.
  - E9–E10: writes blocked; wr_data holds 8.
  - E11–E18: reads 0..7; empty=1 after E18.
  - E19–E20: reads blocked.
  - E21: write 8, read blocked; count=1.
  - E22 onward: one push and one pop per edge; count stays 1; pointers wrap every 8 operations.

## Test plan
- Power-up without reset edge, then 30 clocks -> behaviour identical to post-reset; err=0 throughout.
- Reset (rst=0 for one edge), then 8 edges -> count=8, full=1, empty=0, wr_data=8, rd_data=0.
- Edges 9–10 -> wr_ptr unchanged, count stays 8, no overwrite (rd_data still 0).
- Edges 11–20 -> values 0..7 popped in order, exp_data=8, empty=1, count=0, rd_ptr stays 8 on blocked reads, err=0.
- Edges 21–30 -> pushes 8..17 and pops 8..16; count=1; wr_ptr and rd_ptr low bits wrap past 7; err=0.
- rst=0 at edge 5 -> on that edge all registers reset; next edge writes value 0 again at tick 0.
